// File: rtl/bist_misr_checker_pkg.sv
// Purpose: shared definitions for the BIST response path: FSM state encoding
//          and default MISR width, polynomial and seed. The pattern-generator
//          LFSR uses the same defaults so both ends agree on the arithmetic.
package bist_misr_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COMPACT = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int          DEF_SIG_W = 16;
    localparam logic [15:0] DEF_POLY  = 16'h1021;
    localparam logic [15:0] DEF_SEED  = 16'h0000;

endpackage

// File: rtl/misr_core.sv
// Purpose: Galois-form multiple-input signature register with seed load and
//          shift-compact enables.
// Latency: one clock per compacted word; signature is the register output.
// Backpressure: none; the caller gates 'shift' to the cycles it wants folded in.
// Ports: clock/reset (async active-low), load (reload SEED), shift (fold
//        resp_in into the register), resp_in, sig (current contents).
module misr_core
    import bist_misr_checker_pkg::*;
#(
    parameter int                RESP_W = 2,
    parameter int                SIG_W  = DEF_SIG_W,
    parameter logic [SIG_W-1:0]  POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0]  SEED   = SIG_W'(DEF_SEED)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [RESP_W-1:0] resp_in,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] sig_q;

    // Load has priority over shift so a new run always starts from SEED.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (shift) begin
            // x^SIG_W term is implicit: the bit shifted out selects the taps.
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(resp_in);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_misr_checker.sv
// Purpose: BIST response checker; compacts PATTERNS response words into a MISR,
//          then compares against golden_sig and reports done/pass_nfail.
// Latency: done rises one edge after the edge that accepts the final capture.
// Backpressure: none; capture_en is honoured only in COMPACT, dropped elsewhere.
// Ports: clock, reset (async active-low), start (restart pulse), capture_en +
//        resp_in (response word), golden_sig (expected signature), busy, done,
//        pass_nfail, signature, cap_count (captures accepted this run).
module bist_misr_checker
    import bist_misr_checker_pkg::*;
#(
    parameter int                RESP_W   = 2,
    parameter int                SIG_W    = DEF_SIG_W,
    parameter logic [SIG_W-1:0]  POLY     = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0]  SEED     = SIG_W'(DEF_SEED),
    parameter int                PATTERNS = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            capture_en,
    input  logic [RESP_W-1:0]               resp_in,
    input  logic [SIG_W-1:0]                golden_sig,
    output logic                            busy,
    output logic                            done,
    output logic                            pass_nfail,
    output logic [SIG_W-1:0]                signature,
    output logic [$clog2(PATTERNS+1)-1:0]   cap_count
);

    localparam int CNT_W = $clog2(PATTERNS + 1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cap_count_d, cap_count_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             pass_nfail_d, pass_nfail_q;
    logic             misr_load;
    logic             misr_shift;
    logic [SIG_W-1:0] misr_sig;

    always_comb begin
        state_d      = state_q;
        cap_count_d  = cap_count_q;
        done_d       = done_q;
        pass_nfail_d = pass_nfail_q;
        misr_load    = 1'b0;
        misr_shift   = 1'b0;

        if (start) begin
            // Restart from any state; a capture in the same cycle is dropped
            // and any previous result is withdrawn.
            state_d      = ST_CLEAR;
            done_d       = 1'b0;
            pass_nfail_d = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    misr_load   = 1'b1;
                    cap_count_d = '0;
                    state_d     = ST_COMPACT;
                end
                ST_COMPACT: begin
                    if (capture_en) begin
                        misr_shift  = 1'b1;
                        cap_count_d = cap_count_q + CNT_W'(1);
                        if (cap_count_q == CNT_W'(PATTERNS - 1)) begin
                            state_d = ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    pass_nfail_d = (misr_sig == golden_sig);
                    done_d       = 1'b1;
                    state_d      = ST_DONE;
                end
                ST_IDLE, ST_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // busy is registered from the next state so it tracks CLEAR/COMPACT
        // without a decode path on the output.
        busy_d = (state_d == ST_CLEAR) || (state_d == ST_COMPACT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cap_count_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_nfail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_count_q  <= cap_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_nfail_q <= pass_nfail_d;
        end
    end

    misr_core #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clock   (clock),
        .reset   (reset),
        .load    (misr_load),
        .shift   (misr_shift),
        .resp_in (resp_in),
        .sig     (misr_sig)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_nfail = pass_nfail_q;
    assign signature  = misr_sig;
    assign cap_count  = cap_count_q;

endmodule
